// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer with NUM_CMP compare channels, tick prescaler and Cause.IP assembly.
// Optional macro CP0_INT_SYNC_EN adds a 2-flop synchroniser on ext_int_in (3-cycle latency).
module cp0_timer_intc #(
  parameter int NUM_EXT  = 6,
  parameter int NUM_CMP  = 2,
  parameter int TICK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mtc0_we,
  input  logic [7:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  output logic               rd_hit,
  input  logic [NUM_EXT-1:0] ext_int_in,
  input  logic [1:0]         sw_ip,
  input  logic [7:0]         status_im,
  input  logic               status_ie,
  input  logic               status_exl,
  output logic [7:0]         cause_ip,
  output logic               cause_ti,
  output logic [NUM_CMP-1:0] ti_vec,
  output logic               has_int
);

  localparam int         DIV_W         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_CMP_BASE = 8'h58;

  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [31:0]        count;
  logic [31:0]        compare [NUM_CMP];
  logic               count_we;
  logic [NUM_CMP-1:0] cmp_we;
  logic [NUM_CMP-1:0] match;
  logic [NUM_EXT-1:0] ext_q;
  logic [5:0]         ext_pad;

  assign tick     = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign count_we = mtc0_we && (cp0_addr == ADDR_COUNT);

  // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cmp_we = '0;
    match  = '0;
    for (int k = 0; k < NUM_CMP; k++) begin
      cmp_we[k] = mtc0_we && (cp0_addr == 8'(ADDR_CMP_BASE + 8'(k)));
      match[k]  = (count == compare[k]);
    end
  end

  // A COUNT write restarts the prescaler and overrides a same-cycle tick.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      count   <= '0;
    end else if (count_we) begin
      div_cnt <= '0;
      count   <= cp0_wdata;
    end else if (tick) begin
      div_cnt <= '0;
      count   <= count + 32'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Match compares pre-write register values; a compare write in the same cycle wins.
  // NOTE: the compare bank is reset because its reset value (all ones) is software-visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      ti_vec <= '0;
      for (int k = 0; k < NUM_CMP; k++) compare[k] <= 32'hFFFF_FFFF;
    end else begin
      for (int k = 0; k < NUM_CMP; k++) begin
        if (cmp_we[k]) begin
          compare[k] <= cp0_wdata;
          ti_vec[k]  <= 1'b0;
        end else if (match[k]) begin
          ti_vec[k]  <= 1'b1;
        end
      end
    end
  end

`ifdef CP0_INT_SYNC_EN
  logic [NUM_EXT-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      ext_q   <= '0;
    end else begin
      sync_q1 <= ext_int_in;
      sync_q2 <= sync_q1;
      ext_q   <= sync_q2;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) ext_q <= '0;
    else       ext_q <= ext_int_in;
  end
`endif

  // Unused external lines read as zero in the IP field.
  always_comb begin
    ext_pad                = '0;
    ext_pad[NUM_EXT-1:0]   = ext_q;
  end

  assign cause_ti = |ti_vec;
  assign cause_ip = {ext_pad[5] | cause_ti, ext_pad[4:0], sw_ip};
  assign has_int  = (|(cause_ip & status_im)) & status_ie & ~status_exl;

  always_comb begin
    cp0_rdata = '0;
    rd_hit    = 1'b0;
    if (cp0_addr == ADDR_COUNT) begin
      cp0_rdata = count;
      rd_hit    = 1'b1;
    end
    for (int k = 0; k < NUM_CMP; k++) begin
      if (cp0_addr == 8'(ADDR_CMP_BASE + 8'(k))) begin
        cp0_rdata = compare[k];
        rd_hit    = 1'b1;
      end
    end
  end

endmodule
